// File: rtl/rx8b10b_pkg.sv
// ---------------------------------------------------------------------------
// rx8b10b_pkg
// Shared definitions for the 8b/10b receive-lane synchronization path:
//   SYMBOL_W      - width of one line symbol
//   K28_5_RDN/RDP - the K28.5 comma in both running disparities
//   sync_state_e  - lane synchronization FSM states
//   is_k28_5()    - comma detector used on the alignment window
// ---------------------------------------------------------------------------
package rx8b10b_pkg;

   localparam int unsigned SYMBOL_W = 10;

   localparam logic [SYMBOL_W-1:0] K28_5_RDN = 10'b0011111010;
   localparam logic [SYMBOL_W-1:0] K28_5_RDP = 10'b1100000101;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      PRESYNC = 2'd1,
      SYNC    = 2'd2
   } sync_state_e;

   function automatic logic is_k28_5(input logic [SYMBOL_W-1:0] sym);
      return (sym == K28_5_RDN) || (sym == K28_5_RDP);
   endfunction

endpackage

// File: rtl/word_aligner.sv
// ---------------------------------------------------------------------------
// word_aligner
// Shifts the serial stream into a 10-bit window, flags a K28.5 comma in the
// window and emits aligned symbols on the word boundary.
//   clk_i, rst_i  - bit clock, asynchronous active-high reset
//   i_bit         - serial data bit (first-received bit ends up in bit 0)
//   i_load        - restart the word boundary on the current window
//   i_emit_en     - allow emission at the regular word boundary
//   o_match       - window currently holds a K28.5 comma
//   o_word        - last emitted symbol
//   o_word_valid  - one-cycle pulse, o_word is new
//   o_word_comma  - o_word is a K28.5 comma
//   o_word_load   - o_word was emitted by i_load rather than by the boundary
// ---------------------------------------------------------------------------
module word_aligner
   import rx8b10b_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                i_bit,
   input  logic                i_load,
   input  logic                i_emit_en,
   output logic                o_match,
   output logic [SYMBOL_W-1:0] o_word,
   output logic                o_word_valid,
   output logic                o_word_comma,
   output logic                o_word_load
);

   localparam logic [3:0] LAST_BIT = 4'd9;

   logic [SYMBOL_W-1:0] r_win;
   logic [3:0]          r_bit_cnt;
   logic [SYMBOL_W-1:0] r_word;
   logic                r_word_valid;
   logic                r_word_comma;
   logic                r_word_load;
   logic                w_emit;

   assign o_match = is_k28_5(r_win);
   // A load emits the comma that caused it; afterwards every 10th bit.
   assign w_emit  = i_load | (i_emit_en & (r_bit_cnt == LAST_BIT));

   // Serial shift window, newest bit enters at the top.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_win <= {SYMBOL_W{1'b0}};
      end else begin
         r_win <= {i_bit, r_win[SYMBOL_W-1:1]};
      end
   end

   // Bit position within the symbol; a load makes the next cycle bit 0.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_bit_cnt <= 4'd0;
      end else if (i_load || (r_bit_cnt == LAST_BIT)) begin
         r_bit_cnt <= 4'd0;
      end else begin
         r_bit_cnt <= r_bit_cnt + 4'd1;
      end
   end

   // Registered symbol output and its side flags.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_word       <= {SYMBOL_W{1'b0}};
         r_word_valid <= 1'b0;
         r_word_comma <= 1'b0;
         r_word_load  <= 1'b0;
      end else begin
         r_word_valid <= w_emit;
         if (w_emit) begin
            r_word       <= r_win;
            r_word_comma <= o_match;
            r_word_load  <= i_load;
         end
      end
   end

   assign o_word       = r_word;
   assign o_word_valid = r_word_valid;
   assign o_word_comma = r_word_comma;
   assign o_word_load  = r_word_load;

endmodule

// File: rtl/rx_sync_ctrl.sv
// ---------------------------------------------------------------------------
// rx_sync_ctrl
// Receive-lane synchronization controller: finds K28.5 alignment, emits
// aligned symbols to the 8b/10b decoder and uses the decoder error flag to
// declare and drop lane sync.
//   clk_i        - receive bit clock, one serial bit per cycle
//   rst_i        - asynchronous active-high reset
//   inputdata_i  - serial data bit
//   code_err_i   - decoder error for word_o, used while word_valid_o=1
//   word_o       - aligned symbol
//   word_valid_o - one-cycle pulse, word_o is new
//   synced_o     - lane is in SYNC
//   lost_sync_o  - one-cycle pulse on SYNC->HUNT
//   state_o      - HUNT=0, PRESYNC=1, SYNC=2
// ---------------------------------------------------------------------------
module rx_sync_ctrl
   import rx8b10b_pkg::*;
#(
   parameter int unsigned NUM_COMMA = 3,
   parameter int unsigned ERR_MAX   = 4,
   parameter int unsigned GOOD_RUN  = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                inputdata_i,
   input  logic                code_err_i,
   output logic [SYMBOL_W-1:0] word_o,
   output logic                word_valid_o,
   output logic                synced_o,
   output logic                lost_sync_o,
   output logic [1:0]          state_o
);

   localparam logic [4:0] NUM_COMMA_C = 5'(NUM_COMMA);
   localparam logic [4:0] ERR_MAX_C   = 5'(ERR_MAX);
   localparam logic [4:0] GOOD_RUN_C  = 5'(GOOD_RUN);

   sync_state_e r_state;
   sync_state_e w_state_nxt;
   logic [2:0]  r_comma_cnt, w_comma_nxt;
   logic [2:0]  r_err_cnt, w_err_nxt;
   logic [3:0]  r_good_cnt, w_good_nxt;
   logic [4:0]  w_comma_sum, w_err_sum, w_good_sum;
   logic        w_match, w_load, w_emit_en;
   logic        w_word_valid, w_word_comma, w_word_load;
   logic        w_synced_nxt, w_lost_nxt;
   logic        r_synced, r_lost;

   // Only HUNT may (re)align; PRESYNC and SYNC run on the locked boundary.
   assign w_load    = (r_state == HUNT) & w_match;
   assign w_emit_en = (r_state != HUNT);

   word_aligner u_aligner (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .i_bit        (inputdata_i),
      .i_load       (w_load),
      .i_emit_en    (w_emit_en),
      .o_match      (w_match),
      .o_word       (word_o),
      .o_word_valid (w_word_valid),
      .o_word_comma (w_word_comma),
      .o_word_load  (w_word_load)
   );

   // State and counter registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= HUNT;
         r_comma_cnt <= 3'd0;
         r_err_cnt   <= 3'd0;
         r_good_cnt  <= 4'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_comma_cnt <= w_comma_nxt;
         r_err_cnt   <= w_err_nxt;
         r_good_cnt  <= w_good_nxt;
      end
   end

   // Next-state and counter update, evaluated on each emitted word.
   always_comb begin
      w_state_nxt = r_state;
      w_comma_nxt = r_comma_cnt;
      w_err_nxt   = r_err_cnt;
      w_good_nxt  = r_good_cnt;
      // The word emitted by the HUNT load was already counted as comma 1.
      w_comma_sum = {2'b00, r_comma_cnt} + {4'b0000, (w_word_comma & ~w_word_load)};
      w_err_sum   = {2'b00, r_err_cnt} + 5'd1;
      w_good_sum  = {1'b0, r_good_cnt} + 5'd1;
      case (r_state)
         HUNT: begin
            if (w_match) begin
               w_state_nxt = PRESYNC;
               w_comma_nxt = 3'd1;
            end else begin
               w_state_nxt = HUNT;
            end
         end
         PRESYNC: begin
            if (!w_word_valid) begin
               w_state_nxt = PRESYNC;
            end else if (code_err_i) begin
               // Error wins even when the word is a comma.
               w_state_nxt = HUNT;
               w_comma_nxt = 3'd0;
            end else if (w_comma_sum >= NUM_COMMA_C) begin
               w_state_nxt = SYNC;
               w_comma_nxt = 3'd0;
               w_err_nxt   = 3'd0;
               w_good_nxt  = 4'd0;
            end else begin
               w_comma_nxt = w_comma_sum[2:0];
            end
         end
         SYNC: begin
            if (!w_word_valid) begin
               w_state_nxt = SYNC;
            end else if (code_err_i) begin
               if (w_err_sum >= ERR_MAX_C) begin
                  w_state_nxt = HUNT;
                  w_comma_nxt = 3'd0;
                  w_err_nxt   = 3'd0;
                  w_good_nxt  = 4'd0;
               end else begin
                  w_err_nxt  = w_err_sum[2:0];
                  w_good_nxt = 4'd0;
               end
            end else if (r_err_cnt != 3'd0) begin
               // A full run of good words forgives one error.
               if (w_good_sum >= GOOD_RUN_C) begin
                  w_err_nxt  = r_err_cnt - 3'd1;
                  w_good_nxt = 4'd0;
               end else begin
                  w_good_nxt = w_good_sum[3:0];
               end
            end else if (w_good_sum > GOOD_RUN_C) begin
               w_good_nxt = r_good_cnt;
            end else begin
               w_good_nxt = w_good_sum[3:0];
            end
         end
         default: begin
            w_state_nxt = HUNT;
            w_comma_nxt = 3'd0;
            w_err_nxt   = 3'd0;
            w_good_nxt  = 4'd0;
         end
      endcase
   end

   // Output decode from the transition being taken this cycle.
   always_comb begin
      w_synced_nxt = (w_state_nxt == SYNC);
      w_lost_nxt   = (r_state == SYNC) && (w_state_nxt == HUNT);
   end

   // Output registers, aligned with the state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_synced <= 1'b0;
         r_lost   <= 1'b0;
      end else begin
         r_synced <= w_synced_nxt;
         r_lost   <= w_lost_nxt;
      end
   end

   assign word_valid_o = w_word_valid;
   assign synced_o     = r_synced;
   assign lost_sync_o  = r_lost;
   assign state_o      = r_state;

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rx_sync_ctrl
// Directed bench for rx_sync_ctrl: a table of word slots for the first lock
// and error run, plus hand-written sequences for the multi-cycle cases.
// ---------------------------------------------------------------------------
module tb_rx_sync_ctrl;

   localparam logic [9:0] RDN  = 10'b0011111010;
   localparam logic [9:0] RDP  = 10'b1100000101;
   localparam logic [9:0] D00  = 10'b1001110100;
   localparam logic [9:0] ZERO = 10'b0000000000;
   // Comma straddling two symbols at bit offset 5.
   localparam logic [9:0] SPLIT_A = 10'b1101000000;
   localparam logic [9:0] SPLIT_B = 10'b0000000111;
   localparam logic [1:0] ST_HUNT = 2'd0;
   localparam logic [1:0] ST_PRE  = 2'd1;
   localparam logic [1:0] ST_SYNC = 2'd2;

   logic       clk_i;
   logic       rst_i;
   logic       inputdata_i;
   logic       code_err_i;
   logic [9:0] word_o;
   logic       word_valid_o;
   logic       synced_o;
   logic       lost_sync_o;
   logic [1:0] state_o;

   int n_pass;
   int n_total;

   typedef struct {
      logic [9:0] w;     // word expected on word_o
      logic       e;     // code_err_i returned for that word
      logic [9:0] nxt;   // symbol transmitted meanwhile
      logic [1:0] sv;    // state while word_valid_o is high
      logic [1:0] sn;    // state after the word is consumed
      logic       syn;   // synced_o after the word is consumed
      logic       lst;   // lost_sync_o after the word is consumed
   } vec_t;

   vec_t tbl [10];

   rx_sync_ctrl dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .inputdata_i  (inputdata_i),
      .code_err_i   (code_err_i),
      .word_o       (word_o),
      .word_valid_o (word_valid_o),
      .synced_o     (synced_o),
      .lost_sync_o  (lost_sync_o),
      .state_o      (state_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic b, input logic e);
      inputdata_i = b;
      code_err_i  = e;
      @(posedge clk_i);
      #1;
   endtask

   // Shift in a symbol while hunting; nothing may be emitted meanwhile.
   task automatic hunt_bits(input logic [9:0] sym, input string tag);
      logic quiet;
      quiet = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc(sym[i], 1'b0);
         if (word_valid_o !== 1'b0 || state_o !== ST_HUNT || synced_o !== 1'b0)
            quiet = 1'b0;
      end
      chk({tag, " hunt quiet"}, 32'(quiet), 32'd1);
   endtask

   // One word slot: the word w sits in the window at entry; nxt is shifted
   // in while w is emitted and its error flag is returned.
   task automatic word_slot(input logic [9:0] w, input logic e, input logic [9:0] nxt,
                            input logic [1:0] sv, input logic [1:0] sn,
                            input logic syn, input logic lst, input string tag);
      logic quiet;
      cyc(nxt[0], 1'b0);
      chk({tag, " valid"}, 32'(word_valid_o), 32'd1);
      chk({tag, " word"}, 32'(word_o), 32'(w));
      chk({tag, " state@valid"}, 32'(state_o), 32'(sv));
      cyc(nxt[1], e);
      chk({tag, " state"}, 32'(state_o), 32'(sn));
      chk({tag, " synced"}, 32'(synced_o), 32'(syn));
      chk({tag, " lost"}, 32'(lost_sync_o), 32'(lst));
      chk({tag, " valid pulse"}, 32'(word_valid_o), 32'd0);
      quiet = 1'b1;
      for (int i = 2; i < 10; i++) begin
         cyc(nxt[i], 1'b0);
         if (word_valid_o !== 1'b0 || lost_sync_o !== 1'b0 || state_o !== sn)
            quiet = 1'b0;
      end
      chk({tag, " quiet"}, 32'(quiet), 32'd1);
   endtask

   function automatic logic [14:0] all_out();
      return {word_o, word_valid_o, synced_o, lost_sync_o, state_o};
   endfunction

   initial begin
      n_pass      = 0;
      n_total     = 0;
      rst_i       = 1'b1;
      inputdata_i = 1'b0;
      code_err_i  = 1'b0;

      tbl[0] = '{RDN,     1'b0, D00,     ST_PRE,  ST_PRE,  1'b0, 1'b0};
      tbl[1] = '{D00,     1'b0, RDN,     ST_PRE,  ST_PRE,  1'b0, 1'b0};
      tbl[2] = '{RDN,     1'b0, RDN,     ST_PRE,  ST_PRE,  1'b0, 1'b0};
      tbl[3] = '{RDN,     1'b0, SPLIT_A, ST_PRE,  ST_SYNC, 1'b1, 1'b0};
      tbl[4] = '{SPLIT_A, 1'b0, SPLIT_B, ST_SYNC, ST_SYNC, 1'b1, 1'b0};
      tbl[5] = '{SPLIT_B, 1'b0, D00,     ST_SYNC, ST_SYNC, 1'b1, 1'b0};
      tbl[6] = '{D00,     1'b1, D00,     ST_SYNC, ST_SYNC, 1'b1, 1'b0};
      tbl[7] = '{D00,     1'b1, D00,     ST_SYNC, ST_SYNC, 1'b1, 1'b0};
      tbl[8] = '{D00,     1'b1, D00,     ST_SYNC, ST_SYNC, 1'b1, 1'b0};
      tbl[9] = '{D00,     1'b1, ZERO,    ST_SYNC, ST_HUNT, 1'b0, 1'b1};

      // Reset and idle zeros.
      #12;
      chk("reset outputs", 32'(all_out()), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      for (int i = 0; i < 50; i++) begin
         cyc(1'b0, 1'b0);
         chk($sformatf("idle%0d", i), 32'(all_out()), 32'd0);
      end

      // Junk, then lock on RD- comma, D0.0, comma, comma; then an offset
      // comma in SYNC and four consecutive errors.
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      hunt_bits(RDN, "lock1");
      for (int r = 0; r < 10; r++) begin
         word_slot(tbl[r].w, tbl[r].e, tbl[r].nxt, tbl[r].sv, tbl[r].sn,
                   tbl[r].syn, tbl[r].lst, $sformatf("row%0d", r));
      end

      // Re-lock, then 100 words alternating one error with four good ones.
      hunt_bits(RDN, "lock2");
      word_slot(RDN, 1'b0, RDN, ST_PRE, ST_PRE, 1'b0, 1'b0, "lock2 c1");
      word_slot(RDN, 1'b0, RDN, ST_PRE, ST_PRE, 1'b0, 1'b0, "lock2 c2");
      word_slot(RDN, 1'b0, D00, ST_PRE, ST_SYNC, 1'b1, 1'b0, "lock2 c3");
      for (int w = 0; w < 100; w++) begin
         word_slot(D00, (w % 5 == 0), D00, ST_SYNC, ST_SYNC, 1'b1, 1'b0,
                   $sformatf("alt%0d", w));
      end

      // Three errors, four good (error count back to 2), then two errors.
      word_slot(D00, 1'b1, D00, ST_SYNC, ST_SYNC, 1'b1, 1'b0, "dec e1");
      word_slot(D00, 1'b1, D00, ST_SYNC, ST_SYNC, 1'b1, 1'b0, "dec e2");
      word_slot(D00, 1'b1, D00, ST_SYNC, ST_SYNC, 1'b1, 1'b0, "dec e3");
      for (int g = 0; g < 4; g++) begin
         word_slot(D00, 1'b0, D00, ST_SYNC, ST_SYNC, 1'b1, 1'b0, $sformatf("dec g%0d", g));
      end
      word_slot(D00, 1'b1, D00,  ST_SYNC, ST_SYNC, 1'b1, 1'b0, "dec e4");
      word_slot(D00, 1'b1, ZERO, ST_SYNC, ST_HUNT, 1'b0, 1'b1, "dec e5");

      // Error on a comma in PRESYNC after two commas, then a fresh lock.
      hunt_bits(RDN, "pre");
      word_slot(RDN, 1'b0, RDN,  ST_PRE, ST_PRE,  1'b0, 1'b0, "pre c1");
      word_slot(RDN, 1'b0, RDN,  ST_PRE, ST_PRE,  1'b0, 1'b0, "pre c2");
      word_slot(RDN, 1'b1, ZERO, ST_PRE, ST_HUNT, 1'b0, 1'b0, "pre err");
      hunt_bits(RDN, "fresh");
      word_slot(RDN, 1'b0, RDN, ST_PRE,  ST_PRE,  1'b0, 1'b0, "fresh c1");
      word_slot(RDN, 1'b0, RDN, ST_PRE,  ST_PRE,  1'b0, 1'b0, "fresh c2");
      word_slot(RDN, 1'b0, D00, ST_PRE,  ST_SYNC, 1'b1, 1'b0, "fresh c3");
      word_slot(D00, 1'b0, D00, ST_SYNC, ST_SYNC, 1'b1, 1'b0, "fresh d");

      // Reset in the middle of a word while in SYNC.
      for (int i = 0; i < 4; i++) cyc(D00[i], 1'b0);
      #2;
      rst_i = 1'b1;
      #1;
      chk("async reset clear", 32'(all_out()), 32'd0);
      @(posedge clk_i);
      #1;
      chk("reset held", 32'(all_out()), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      hunt_bits(RDP, "rst");
      word_slot(RDP, 1'b0, RDP, ST_PRE,  ST_PRE,  1'b0, 1'b0, "rst c1");
      word_slot(RDP, 1'b0, RDP, ST_PRE,  ST_PRE,  1'b0, 1'b0, "rst c2");
      word_slot(RDP, 1'b0, D00, ST_PRE,  ST_SYNC, 1'b1, 1'b0, "rst c3");
      word_slot(D00, 1'b0, D00, ST_SYNC, ST_SYNC, 1'b1, 1'b0, "rst d");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
